// File: rtl/cam_pkg.sv
// ---------------------------------------------------------------------------
// cam_pkg : shared definitions for the right-eye camera capture path and the
//           VGA reader that scans the same frame RAM.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package cam_pkg;

  // Capture sequencing states
  typedef enum logic [1:0] {
    S_WAIT_VS    = 2'd0,
    S_WAIT_START = 2'd1,
    S_CAPTURE    = 2'd2
  } cam_state_e;

  // Source geometry and crop window defaults
  localparam int CAM_SRC_W = 640;
  localparam int CAM_SRC_H = 480;
  localparam int CAM_X0    = 220;
  localparam int CAM_Y0    = 140;
  localparam int CAM_WIN_W = 200;
  localparam int CAM_WIN_H = 200;

  // Pixels per stored image; the VGA reader scans exactly this many words
  localparam int FRAME_PIX = CAM_WIN_W * CAM_WIN_H;

  // RAM geometry and capture counter widths
  localparam int ADDR_W = 16;
  localparam int PIX_W  = 3;
  localparam int COL_W  = 10;
  localparam int ROW_W  = 9;

endpackage

`default_nettype wire

// File: rtl/cam_sync_edge.sv
// ---------------------------------------------------------------------------
// cam_sync_edge : registers camera vsync/href once and derives edge strobes
//                 from the registered copies.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cam_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic vsync_i,
  input  logic href_i,
  output logic vs_q_o,
  output logic href_q_o,
  output logic vs_rise_o,
  output logic vs_fall_o,
  output logic href_fall_o
);

  logic vs_q;
  logic vs_prev_q;
  logic href_q;
  logic href_prev_q;

  // Input register plus one history stage for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_q        <= 1'b0;
      vs_prev_q   <= 1'b0;
      href_q      <= 1'b0;
      href_prev_q <= 1'b0;
    end else begin
      vs_q        <= vsync_i;
      vs_prev_q   <= vs_q;
      href_q      <= href_i;
      href_prev_q <= href_q;
    end
  end

  assign vs_q_o      = vs_q;
  assign href_q_o    = href_q;
  assign vs_rise_o   = vs_q & ~vs_prev_q;
  assign vs_fall_o   = ~vs_q & vs_prev_q;
  assign href_fall_o = ~href_q & href_prev_q;

endmodule

`default_nettype wire

// File: rtl/rightcam2ram.sv
// ---------------------------------------------------------------------------
// rightcam2ram : captures the right camera's YUV422 stream, crops a
//                WIN_W x WIN_H window and writes 3-bit luma into frame RAM.
// Optional build macro RIGHTCAM_BINARY_EN: stores a thresholded (THRESH)
// binary luma instead of the luma MSBs.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rightcam2ram
  import cam_pkg::*;
#(
  parameter int SRC_W   = CAM_SRC_W,
  parameter int SRC_H   = CAM_SRC_H,
  parameter int X0      = CAM_X0,
  parameter int Y0      = CAM_Y0,
  parameter int WIN_W   = CAM_WIN_W,
  parameter int WIN_H   = CAM_WIN_H,
  parameter int Y_FIRST = 1
`ifdef RIGHTCAM_BINARY_EN
  ,
  parameter logic [7:0] THRESH = 8'd128
`endif
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_d,
  input  logic              freeze,
  output logic              wrclk,
  output logic [ADDR_W-1:0] wraddr,
  output logic [PIX_W-1:0]  wrdata,
  output logic              wren,
  output logic              frame_done,
  output logic              frame_short
);

  localparam logic [COL_W-1:0]  X_LO      = COL_W'(X0);
  localparam logic [COL_W-1:0]  X_HI      = COL_W'(X0 + WIN_W - 1);
  localparam logic [ROW_W-1:0]  Y_LO      = ROW_W'(Y0);
  localparam logic [ROW_W-1:0]  Y_HI      = ROW_W'(Y0 + WIN_H - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIN_W * WIN_H - 1);
  // Byte phase on which the luma byte arrives within each YUV pair
  localparam logic              Y_PHASE   = (Y_FIRST == 0);
  // A window that cannot fit in the source frame (or the RAM) can never
  // complete, so capture is disabled outright rather than writing garbage.
  localparam bit CFG_OK = (X0 + WIN_W <= SRC_W) && (Y0 + WIN_H <= SRC_H) &&
                          (WIN_W * WIN_H <= 65536) && (X0 + WIN_W <= 1023) &&
                          (Y0 + WIN_H <= 511) && (WIN_W > 0) && (WIN_H > 0);

  logic              vs_q;
  logic              href_q;
  logic              vs_rise_w;
  logic              vs_fall_w;
  logic              href_fall_w;
  logic [7:0]        d_q;
  logic              phase_q;
  logic [COL_W-1:0]  col_q;
  logic [ROW_W-1:0]  row_q;
  logic [ADDR_W-1:0] addr_q;
  cam_state_e        state_q;
  logic              done_pend_q;
  logic              frame_done_q;
  logic              frame_short_q;
  logic              wren_q;
  logic [ADDR_W-1:0] wraddr_q;
  logic [PIX_W-1:0]  wrdata_q;

  logic              y_byte_w;
  logic              in_win_w;
  logic              hit_w;
  logic              hit_last_w;
  logic              start_w;
  logic [PIX_W-1:0]  pix_w;

  cam_sync_edge u_sync (
    .clk        (pclk),
    .rst        (rst),
    .vsync_i    (cam_vsync),
    .href_i     (cam_href),
    .vs_q_o     (vs_q),
    .href_q_o   (href_q),
    .vs_rise_o  (vs_rise_w),
    .vs_fall_o  (vs_fall_w),
    .href_fall_o(href_fall_w)
  );

  // Data byte registered alongside vsync/href so all decisions line up
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) d_q <= 8'd0;
    else     d_q <= cam_d;
  end

`ifdef RIGHTCAM_BINARY_EN
  assign pix_w = (d_q >= THRESH) ? {PIX_W{1'b1}} : {PIX_W{1'b0}};
`else
  logic unused_lsbs_w;
  assign pix_w         = d_q[7:5];
  assign unused_lsbs_w = ^d_q[4:0];
`endif

  assign y_byte_w   = href_q && (phase_q == Y_PHASE);
  assign in_win_w   = (col_q >= X_LO) && (col_q <= X_HI) &&
                      (row_q >= Y_LO) && (row_q <= Y_HI);
  assign hit_w      = CFG_OK && (state_q == S_CAPTURE) && y_byte_w && in_win_w;
  assign hit_last_w = hit_w && (addr_q == LAST_ADDR);
  assign start_w    = (state_q == S_WAIT_START) && vs_fall_w && !freeze;

  // Byte phase within a YUV pair; restarts at each line
  always_ff @(posedge pclk or posedge rst) begin
    if (rst)         phase_q <= 1'b0;
    else if (!href_q) phase_q <= 1'b0;
    else             phase_q <= ~phase_q;
  end

  // Column/row/address counters; saturation stops wrap-around false hits
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      col_q  <= '0;
      row_q  <= '0;
      addr_q <= '0;
    end else if (start_w) begin
      col_q  <= '0;
      row_q  <= '0;
      addr_q <= '0;
    end else begin
      if (href_fall_w)                  col_q <= '0;
      else if (y_byte_w && (col_q != '1)) col_q <= col_q + 1'b1;
      if ((state_q == S_CAPTURE) && href_fall_w && (row_q != '1))
        row_q <= row_q + 1'b1;
      if (hit_w) addr_q <= addr_q + 1'b1;
    end
  end

  // RAM write port: one-cycle strobe, address/data held between writes
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      wren_q   <= 1'b0;
      wraddr_q <= '0;
      wrdata_q <= '0;
    end else begin
      wren_q <= hit_w;
      if (hit_w) begin
        wraddr_q <= addr_q;
        wrdata_q <= pix_w;
      end
    end
  end

  // Frame sequencing; completion takes priority over a coincident vsync rise
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q       <= S_WAIT_VS;
      done_pend_q   <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_short_q <= 1'b0;
    end else begin
      done_pend_q   <= 1'b0;
      frame_done_q  <= done_pend_q;
      frame_short_q <= 1'b0;
      case (state_q)
        S_WAIT_VS: begin
          if (vs_q) state_q <= S_WAIT_START;
        end
        S_WAIT_START: begin
          if (start_w) state_q <= S_CAPTURE;
        end
        S_CAPTURE: begin
          if (hit_last_w) begin
            done_pend_q <= 1'b1;
            state_q     <= S_WAIT_VS;
          end else if (vs_rise_w) begin
            frame_short_q <= 1'b1;
            state_q       <= S_WAIT_START;
          end
        end
        default: state_q <= S_WAIT_VS;
      endcase
    end
  end

  assign wrclk       = pclk;
  assign wren        = wren_q;
  assign wraddr      = wraddr_q;
  assign wrdata      = wrdata_q;
  assign frame_done  = frame_done_q;
  assign frame_short = frame_short_q;

endmodule

`default_nettype wire

// File: tb/tb_rightcam2ram.sv
// ---------------------------------------------------------------------------
// tb_rightcam2ram : scoreboard bench driving one camera stream into a YUYV
//                   and a UYVY configured capture block in parallel.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_rightcam2ram;

  localparam int TB_SRC_W = 48;
  localparam int TB_SRC_H = 32;
  localparam int TB_X0    = 10;
  localparam int TB_Y0    = 6;
  localparam int TB_WIN_W = 20;
  localparam int TB_WIN_H = 16;
  localparam int TB_PIX   = TB_WIN_W * TB_WIN_H;
  localparam int TB_LAST  = TB_PIX - 1;

  typedef struct packed {
    logic [15:0] addr;
    logic [2:0]  data;
  } wr_t;

  logic        pclk = 1'b0;
  logic        rst;
  logic        cam_vsync;
  logic        cam_href;
  logic [7:0]  cam_d;
  logic        freeze;
  logic        wrclk       [2];
  logic [15:0] wraddr      [2];
  logic [2:0]  wrdata      [2];
  logic        wren        [2];
  logic        frame_done  [2];
  logic        frame_short [2];

  wr_t exp_q0[$];
  wr_t exp_q1[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int wr_cnt[2], done_cnt[2], short_cnt[2];
  int wr_snap[2], done_snap[2], short_snap[2];
  int last_wr[2];

  always #5 pclk = ~pclk;

  rightcam2ram #(
    .SRC_W(TB_SRC_W), .SRC_H(TB_SRC_H), .X0(TB_X0), .Y0(TB_Y0),
    .WIN_W(TB_WIN_W), .WIN_H(TB_WIN_H), .Y_FIRST(1)
  ) u_dut_yuyv (
    .pclk(pclk), .rst(rst), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_d(cam_d), .freeze(freeze), .wrclk(wrclk[0]), .wraddr(wraddr[0]),
    .wrdata(wrdata[0]), .wren(wren[0]), .frame_done(frame_done[0]),
    .frame_short(frame_short[0])
  );

  rightcam2ram #(
    .SRC_W(TB_SRC_W), .SRC_H(TB_SRC_H), .X0(TB_X0), .Y0(TB_Y0),
    .WIN_W(TB_WIN_W), .WIN_H(TB_WIN_H), .Y_FIRST(0)
  ) u_dut_uyvy (
    .pclk(pclk), .rst(rst), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_d(cam_d), .freeze(freeze), .wrclk(wrclk[1]), .wraddr(wraddr[1]),
    .wrdata(wrdata[1]), .wren(wren[1]), .frame_done(frame_done[1]),
    .frame_short(frame_short[1])
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Stored pixel value for a given luma byte
  function automatic logic [2:0] exp_pix(input logic [7:0] y);
    logic [2:0] r;
`ifdef RIGHTCAM_BINARY_EN
    r = (y >= 8'd128) ? 3'b111 : 3'b000;
`else
    r = y[7:5];
`endif
    return r;
  endfunction

  // Monitor: pop scoreboard on each write, count pulses, check done latency
  always @(negedge pclk) begin
    wr_t e;
    cyc++;
    if (wren[0]) begin
      wr_cnt[0]++;
      check_eq("sb_entry_yuyv", 32'(exp_q0.size() > 0), 1);
      if (exp_q0.size() > 0) begin
        e = exp_q0.pop_front();
        check_eq("addr_yuyv", 32'(wraddr[0]), 32'(e.addr));
        check_eq("data_yuyv", 32'(wrdata[0]), 32'(e.data));
      end
      if (wraddr[0] == 16'(TB_LAST)) last_wr[0] = cyc;
    end
    if (wren[1]) begin
      wr_cnt[1]++;
      check_eq("sb_entry_uyvy", 32'(exp_q1.size() > 0), 1);
      if (exp_q1.size() > 0) begin
        e = exp_q1.pop_front();
        check_eq("addr_uyvy", 32'(wraddr[1]), 32'(e.addr));
        check_eq("data_uyvy", 32'(wrdata[1]), 32'(e.data));
      end
      if (wraddr[1] == 16'(TB_LAST)) last_wr[1] = cyc;
    end
    for (int i = 0; i < 2; i++) begin
      if (frame_done[i]) begin
        done_cnt[i]++;
        check_eq("done_latency", 32'(cyc - last_wr[i]), 1);
      end
      if (frame_short[i]) short_cnt[i]++;
    end
  end

  task automatic check_outputs_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      check_eq({tag, "_wren"},   32'(wren[i]), 0);
      check_eq({tag, "_wraddr"}, 32'(wraddr[i]), 0);
      check_eq({tag, "_wrdata"}, 32'(wrdata[i]), 0);
      check_eq({tag, "_done"},   32'(frame_done[i]), 0);
      check_eq({tag, "_short"},  32'(frame_short[i]), 0);
    end
  endtask

  // One camera frame. mode 0: Y=pix*8, C=0x80; mode 1: Y=127/128, C=0x80;
  // mode 2: first byte 0x00, second 0xFF. rst_line/rst_pix < 0: no reset.
  task automatic send_frame(input int nlines, input int mode, input bit cap,
                            input int rst_line, input int rst_pix);
    int   eaddr = 0;
    bit   capt  = cap;
    logic [7:0] b0, b1;
    logic [15:0] pv;
    wr_t  e;
    @(negedge pclk);
    cam_vsync = 1'b1;
    cam_href  = 1'b0;
    repeat (6) @(negedge pclk);
    cam_vsync = 1'b0;
    repeat (6) @(negedge pclk);
    for (int l = 0; l < nlines; l++) begin
      for (int p = 0; p < TB_SRC_W; p++) begin
        if (l == rst_line && p == rst_pix) begin
          check_eq("pre_rst_sb_empty", 32'(exp_q0.size() + exp_q1.size()), 0);
          #2 rst = 1'b1;
          #1 check_outputs_zero("async_rst");
          repeat (3) @(negedge pclk);
          rst  = 1'b0;
          capt = 1'b0;
        end
        pv = 16'(p * 8);
        case (mode)
          0:       begin b0 = pv[7:0];                       b1 = 8'h80; end
          1:       begin b0 = (p % 2 == 1) ? 8'd128 : 8'd127; b1 = 8'h80; end
          default: begin b0 = 8'h00;                          b1 = 8'hFF; end
        endcase
        if (capt && l >= TB_Y0 && l < TB_Y0 + TB_WIN_H &&
            p >= TB_X0 && p < TB_X0 + TB_WIN_W) begin
          e.addr = 16'(eaddr);
          e.data = exp_pix(b0);
          exp_q0.push_back(e);
          e.data = exp_pix(b1);
          exp_q1.push_back(e);
          eaddr++;
        end
        cam_href = 1'b1;
        cam_d    = b0;
        @(negedge pclk);
        cam_d    = b1;
        @(negedge pclk);
      end
      cam_href = 1'b0;
      cam_d    = 8'h00;
      repeat (6) @(negedge pclk);
    end
    repeat (6) @(negedge pclk);
  endtask

  task automatic end_frame(input string tag, input int exp_wr, input int exp_done,
                           input int exp_short);
    repeat (4) @(negedge pclk);
    for (int i = 0; i < 2; i++) begin
      check_eq({tag, "_wr_count"},    32'(wr_cnt[i] - wr_snap[i]), 32'(exp_wr));
      check_eq({tag, "_done_count"},  32'(done_cnt[i] - done_snap[i]), 32'(exp_done));
      check_eq({tag, "_short_count"}, 32'(short_cnt[i] - short_snap[i]), 32'(exp_short));
      wr_snap[i]    = wr_cnt[i];
      done_snap[i]  = done_cnt[i];
      short_snap[i] = short_cnt[i];
    end
    check_eq({tag, "_sb_yuyv_left"}, 32'(exp_q0.size()), 0);
    check_eq({tag, "_sb_uyvy_left"}, 32'(exp_q1.size()), 0);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      wr_cnt[i] = 0; done_cnt[i] = 0; short_cnt[i] = 0;
      wr_snap[i] = 0; done_snap[i] = 0; short_snap[i] = 0;
      last_wr[i] = -100;
    end
    rst       = 1'b1;
    cam_vsync = 1'b0;
    cam_href  = 1'b0;
    cam_d     = 8'h00;
    freeze    = 1'b0;
    repeat (4) @(negedge pclk);
    check_outputs_zero("reset");
    rst = 1'b0;
    repeat (4) @(negedge pclk);

    // Full frame, luma ramp
    send_frame(TB_SRC_H, 0, 1'b1, -1, -1);
    end_frame("full_a", TB_PIX, 1, 0);

    // Frame cut early; abort pulse appears at the next vsync rise
    send_frame(TB_Y0 + 5, 0, 1'b1, -1, -1);
    end_frame("short_b", 5 * TB_WIN_W, 0, 0);
    send_frame(TB_SRC_H, 0, 1'b1, -1, -1);
    end_frame("after_short_c", TB_PIX, 1, 1);

    // Frozen frame is not captured; next one is
    freeze = 1'b1;
    send_frame(TB_SRC_H, 0, 1'b0, -1, -1);
    freeze = 1'b0;
    end_frame("freeze_d", 0, 0, 0);

    // Luma straddling the threshold / MSB boundary
    send_frame(TB_SRC_H, 1, 1'b1, -1, -1);
    end_frame("alt_e", TB_PIX, 1, 0);

    // UYVY-shaped stream: chroma 0x00, luma 0xFF
    send_frame(TB_SRC_H, 2, 1'b1, -1, -1);
    end_frame("uyvy_f", TB_PIX, 1, 0);

    // Reset mid-frame: frame abandoned silently
    send_frame(TB_SRC_H, 0, 1'b1, TB_Y0 + 3, 3);
    end_frame("rst_g", 3 * TB_WIN_W, 0, 0);

    // Capture resumes only after a complete vsync cycle
    send_frame(TB_SRC_H, 0, 1'b1, -1, -1);
    end_frame("full_h", TB_PIX, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rightcam2ram.md
Name: rightcam2ram

Overview:
- Upstream stage of the right-eye display path.
- Captures the right camera's YUV422 byte stream (OV7670-style vsync/href/8-bit data) and crops a WIN_W x WIN_H window.
- Reduces each pixel's luma to 3 bits and writes it into the 16-bit-addressed frame RAM that the right-eye VGA reader scans out.
- Writes run on the camera pixel clock; the RAM's read side is independent.

Parameters:
- SRC_W, 640: source pixels per line (YUV pairs per href).
- SRC_H, 480: source lines per frame.
- X0, 220: first cropped column (pixel index within line).
- Y0, 140: first cropped line.
- WIN_W, 200: window width in pixels.
- WIN_H, 200: window height in lines; WIN_W*WIN_H must be at most 65536.
- Y_FIRST, 1: 1 means the Y byte is the first byte of each pair (YUYV); 0 means the second (UYVY).

Ports:
- pclk  in  1  camera pixel clock; also forwarded as the RAM write clock.
- rst  in  1  asynchronous, active-high reset.
- cam_vsync  in  1  camera vsync; high means vertical blank.
- cam_href  in  1  camera line-valid.
- cam_d  in  8  camera data byte.
- freeze  in  1  when high, no new frame capture starts; the RAM holds the last image.
- wrclk  out  1  equals pclk.
- wraddr  out  16  RAM write address.
- wrdata  out  3  RAM write data.
- wren  out  1  RAM write enable.
- frame_done  out  1  one-cycle pulse after the last window pixel is written.
- frame_short  out  1  one-cycle pulse when vsync rises before the window completes.

Behaviour:
- Reset (async, rst high):
  - state = S_WAIT_VS; wraddr = 0; wrdata = 0; wren = 0; frame_done = 0; frame_short = 0.
  - All counters, byte phase and registered vsync/href are cleared.
  - Reset asserted mid-frame abandons the frame; no pulse is issued.
- Inputs are registered once (vs_q, href_q, d_q). All decisions use the registered values.
- FSM:
  - S_WAIT_VS: wait for vs_q = 1, then go to S_WAIT_START.
  - S_WAIT_START: on a vs_q falling edge with freeze = 0, clear col, row and addr counters, then go to S_CAPTURE. With freeze = 1, stay in S_WAIT_START.
  - S_CAPTURE: capture pixels.
    - When the last window pixel is written: frame_done pulses the next cycle, then go to S_WAIT_VS.
    - If a vs_q rising edge arrives first: pulse frame_short and go to S_WAIT_START. Written data stays in RAM; the address restarts at 0 next frame.
- Byte phase: cleared while href_q = 0; toggles on each byte while href_q = 1. The Y byte is phase 0 when Y_FIRST = 1, phase 1 when Y_FIRST = 0.
- col (10 bits): increments after each Y byte; cleared on the href_q falling edge; saturates at 1023.
- row (9 bits): increments on each href_q falling edge in S_CAPTURE; saturates at 511.
- Pixel written when all hold: a Y byte is sampled, X0 <= col <= X0+WIN_W-1, and Y0 <= row <= Y0+WIN_H-1.
- Write timing: on the next cycle, wren = 1, wrdata = Y[7:5], wraddr = addr. addr (16 bits) then increments, so addresses run 0..WIN_W*WIN_H-1 in raster order.
- wren is low on all other cycles. wraddr and wrdata hold their last value when wren = 0.
- Lines longer than SRC_W or frames taller than SRC_H: extra pixels are ignored because they fall outside the window. Counter saturation prevents wrap-around false hits.
- freeze is sampled only in S_WAIT_START. Asserting it mid-capture does not truncate the current frame.
- Final address write (WIN_W*WIN_H-1) and a vsync rise on the same cycle: the write completes and frame_done wins; frame_short is not issued.

Optional Feature:
- Macro: RIGHTCAM_BINARY_EN.
- Defined: adds parameter THRESH (default 8'd128). wrdata = 3'b111 if Y >= THRESH, else 3'b000. Used for stereo edge matching.
- Undefined: wrdata = Y[7:5]. THRESH does not exist.

Decomposition:
- Shared package cam_pkg:
  - FSM state enum (S_WAIT_VS, S_WAIT_START, S_CAPTURE).
  - Window constants WIN_W/WIN_H/X0/Y0 defaults and FRAME_PIX = 40000, shared with the VGA reader.
  - Address width 16 and pixel width 3.
- One natural sub-module: cam_sync_edge. It registers vsync/href and produces rise/fall strobes.

Test Plan:
- Reset, then one 640x480 YUYV frame with Y = col[7:0]:
  - exactly 40000 wren pulses, addresses 0..39999;
  - first write has wrdata = 220[7:5] = 3'b110 at addr 0;
  - frame_done pulses once, 1 cycle after the addr-39999 write.
- Frame cut at line 250 by an early vsync rise: frame_short pulses once, frame_done never pulses. The next full frame restarts at wraddr 0.
- freeze = 1 during vsync fall: zero wren pulses for that frame. Release freeze before the next vsync fall: the next frame is captured fully.
- Y_FIRST = 0 with UYVY stream U = 8'h00, Y = 8'hFF: all writes have wrdata = 3'b111. With the stream misconfigured as YUYV: all writes = 3'b000.
- rst asserted at row 300, col 300: outputs go to 0 immediately with no clock needed. After release, capture waits for the next full vsync cycle.
- RIGHTCAM_BINARY_EN with THRESH = 128, Y alternating 127/128: wrdata alternates 3'b000/3'b111.
